// File: rtl/chopper_timer_sequencer.sv
// Two-channel chopper timing sequencer: per-bridge blank, minimum on-time and fixed off-time
// countdowns, with a shared step detector on the microstep phase counter.
module chopper_timer_sequencer (
  input  logic       clk,
  input  logic       resetn,
  input  logic       enable,
  input  logic [7:0] phase_ct,
  input  logic       offtimer_en0,
  input  logic       offtimer_en1,
  input  logic [7:0] config_blank_cycles,
  input  logic [7:0] config_minon_cycles,
  input  logic [9:0] config_offtime_cycles,
  output logic [7:0] blank_timer0,
  output logic [7:0] blank_timer1,
  output logic [7:0] minimum_on_timer0,
  output logic [7:0] minimum_on_timer1,
  output logic [9:0] off_timer0,
  output logic [9:0] off_timer1,
  output logic [1:0] chop_state0,
  output logic [1:0] chop_state1
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    ON    = 2'd2,
    OFF   = 2'd3
  } chop_state_t;

  logic [7:0]  phase_q;
  logic        step;
  logic [1:0]  offtimer_en;
  chop_state_t state       [2];
  logic [7:0]  blank_timer [2];
  logic [7:0]  minon_timer [2];
  logic [9:0]  off_timer   [2];

  assign step        = (phase_ct != phase_q);
  assign offtimer_en = {offtimer_en1, offtimer_en0};

  // Tracks phase_ct in reset as well, so leaving reset never looks like a step.
  always_ff @(posedge clk) begin
    phase_q <= phase_ct;
  end

  always_ff @(posedge clk) begin
    for (int ch = 0; ch < 2; ch++) begin
      // NOTE: the timer arrays are ordinary flops, so they get an explicit reset like any other state.
      if (!resetn || !enable) begin
        state[ch]       <= IDLE;
        blank_timer[ch] <= 8'd0;
        minon_timer[ch] <= 8'd0;
        off_timer[ch]   <= 10'd0;
      end else begin
        // NOTE: non-blocking, last assignment wins; the reloads below override this default decrement.
        minon_timer[ch] <= (minon_timer[ch] != 8'd0) ? minon_timer[ch] - 8'd1 : 8'd0;
        case (state[ch])
          IDLE: begin
            state[ch]       <= BLANK;
            blank_timer[ch] <= config_blank_cycles;
            minon_timer[ch] <= config_minon_cycles;
            off_timer[ch]   <= 10'd0;
          end
          BLANK: begin
            if (step) begin
              blank_timer[ch] <= config_blank_cycles;
              minon_timer[ch] <= config_minon_cycles;
            end else if (blank_timer[ch] == 8'd0) begin
              state[ch] <= ON;
            end else begin
              blank_timer[ch] <= blank_timer[ch] - 8'd1;
            end
          end
          ON: begin
            // A step outranks an off request; a zero off-time disables the request entirely.
            if (step) begin
              state[ch]       <= BLANK;
              blank_timer[ch] <= config_blank_cycles;
              minon_timer[ch] <= config_minon_cycles;
            end else if (offtimer_en[ch] && (config_offtime_cycles != 10'd0)) begin
              state[ch]     <= OFF;
              off_timer[ch] <= config_offtime_cycles;
            end
          end
          OFF: begin
            // Steps are not looked at here; the blank reload at expiry absorbs them.
            if (off_timer[ch] <= 10'd1) begin
              state[ch]       <= BLANK;
              off_timer[ch]   <= 10'd0;
              blank_timer[ch] <= config_blank_cycles;
              minon_timer[ch] <= config_minon_cycles;
            end else begin
              off_timer[ch] <= off_timer[ch] - 10'd1;
            end
          end
          default: state[ch] <= IDLE;
        endcase
      end
    end
  end

  assign blank_timer0      = blank_timer[0];
  assign blank_timer1      = blank_timer[1];
  assign minimum_on_timer0 = minon_timer[0];
  assign minimum_on_timer1 = minon_timer[1];
  assign off_timer0        = off_timer[0];
  assign off_timer1        = off_timer[1];
  assign chop_state0       = state[0];
  assign chop_state1       = state[1];

endmodule

// File: doc/chopper_timer_sequencer.md
CHOPPER_TIMER_SEQUENCER -- requirements
Module: chopper_timer_sequencer

Interface
REQ-001 SHALL have: clk  input  1  system clock; all state changes on rising edge.
REQ-002 SHALL have: resetn  input  1  reset, synchronous, active-low.
REQ-003 SHALL have: enable  input  1  bridge enable; low forces both channels to IDLE.
REQ-004 SHALL have: phase_ct  input  8  microstep phase counter; any change is a step event.
REQ-005 SHALL have: offtimer_en0 / offtimer_en1  input  1 each  off-time start request, channel A / B.
REQ-006 SHALL have: config_blank_cycles  input  8  blanking length, in clk cycles.
REQ-007 SHALL have: config_minon_cycles  input  8  minimum on-time length, in clk cycles.
REQ-008 SHALL have: config_offtime_cycles  input  10  fixed off-time length, in clk cycles.
REQ-009 SHALL have: blank_timer0 / blank_timer1  output  8 each  blanking countdown.
REQ-010 SHALL have: minimum_on_timer0 / minimum_on_timer1  output  8 each  minimum on-time countdown.
REQ-011 SHALL have: off_timer0 / off_timer1  output  10 each  off-time countdown.
REQ-012 SHALL have: chop_state0 / chop_state1  output  2 each  state: 0 IDLE, 1 BLANK, 2 ON, 3 OFF.

Function
REQ-013 SHALL run two identical, independent channel FSMs: channel 0 uses offtimer_en0 and *0 outputs; channel 1 uses offtimer_en1 and *1 outputs.
REQ-014 SHALL register phase_ct into phase_q every cycle; step event = (phase_ct != phase_q); step affects both channels in the same cycle.
REQ-015 IDLE: all channel timers held 0; on enable high go to BLANK next cycle, loading blank_timer = config_blank_cycles and minimum_on_timer = config_minon_cycles.
REQ-016 BLANK: blank_timer decrements by 1 per cycle; at blank_timer==0 go to ON; config_blank_cycles==0 passes through BLANK in 1 cycle.
REQ-017 minimum_on_timer SHALL decrement by 1 per cycle in BLANK, ON and OFF, saturating at 0, independent of state.
REQ-018 ON: on offtimer_en high, load off_timer = config_offtime_cycles and go to OFF next cycle, even when minimum_on_timer != 0; the downstream fault detector needs the overlap visible.
REQ-019 ON with config_offtime_cycles==0: offtimer_en SHALL be ignored and the channel stays in ON.
REQ-020 OFF: off_timer decrements by 1 per cycle; in the cycle off_timer==1 it goes to 0 and state goes to BLANK, with blank_timer and minimum_on_timer reloaded from config in the same edge.
REQ-021 offtimer_en SHALL be ignored in IDLE, BLANK and OFF.
REQ-022 Step event in BLANK or ON SHALL reload blank_timer and minimum_on_timer from config and enter or stay in BLANK; the reload takes priority over a same-cycle offtimer_en.
REQ-023 Step event in OFF SHALL NOT shorten the off-time; the step is absorbed by the BLANK reload at off expiry.
REQ-024 enable low in any state SHALL go to IDLE next cycle with all timers 0; this takes priority over step and offtimer_en.
REQ-025 Config changes SHALL take effect only at the next timer load; running countdowns are not rescaled.
REQ-026 All outputs SHALL be registered; no combinational path from input to output.
REQ-027 Counters SHALL never underflow: decrement only when nonzero.

Reset
REQ-028 While resetn low at a clk edge: both chop_state = IDLE, all timers = 0, phase_q = phase_ct.
REQ-029 Reset asserted mid-countdown SHALL clear the channel on the next edge with no residual count; after release, behaviour is as from IDLE.

Verification
REQ-030 Config blank=4, minon=10, off=20; enable rises -> blank0 counts 4,3,2,1,0; state BLANK->ON after 5 cycles; minon0 reaches 0 at cycle 10.
REQ-031 In ON with minon=0, pulse offtimer_en0 -> off_timer0 = 20 next cycle, counts to 0, then state BLANK with blank0 = 4 and minon0 = 10 in the same edge.
REQ-032 Pulse offtimer_en1 while minimum_on_timer1 = 6 -> off_timer1 = 20 and minimum_on_timer1 = 5 in the same cycle (overlap visible); channel 0 unaffected.
REQ-033 phase_ct 0x10->0x11 during ON -> both channels go to BLANK with reload; same change during OFF at off_timer = 7 -> countdown continues 6,5,...
REQ-034 Drop enable during OFF at off_timer = 12 -> next cycle state IDLE, all timers 0; re-enable -> BLANK with fresh loads.
REQ-035 config_offtime_cycles = 0 and offtimer_en0 held high -> channel 0 remains ON; off_timer0 stays 0.
